// File: rtl/branch_predict_unit_pkg.sv
// Branch predictor shared definitions: opcodes, REGIMM rt codes,
// 2-bit counter encodings and the saturating counter step.
package branch_predict_unit_pkg;

  localparam logic [5:0] EXE_REGIMM = 6'b000001;
  localparam logic [5:0] EXE_BEQ    = 6'b000100;
  localparam logic [5:0] EXE_BNE    = 6'b000101;
  localparam logic [5:0] EXE_BLEZ   = 6'b000110;
  localparam logic [5:0] EXE_BGTZ   = 6'b000111;

  localparam logic [4:0] EXE_BLTZ   = 5'b00000;
  localparam logic [4:0] EXE_BGEZ   = 5'b00001;
  localparam logic [4:0] EXE_BLTZAL = 5'b10000;
  localparam logic [4:0] EXE_BGEZAL = 5'b10001;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic logic [1:0] ctr_next(
    input logic [1:0] c,
    input logic       tk
  );
    if (tk)
      return (c == ST) ? c : c + 2'd1;
    else
      return (c == SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Decode-stage branch bundle: valid/stall, pc, opcode fields,
// forwarded operands and the prediction carried from fetch.
interface branch_predict_unit_if #(
  parameter int DATA_W = 32
);
  logic              d_valid;
  logic              d_stall;
  logic [31:0]       d_pc;
  logic [5:0]        d_op;
  logic [4:0]        d_rt;
  logic [DATA_W-1:0] d_a;
  logic [DATA_W-1:0] d_b;
  logic              d_pred_taken;

  modport master (
    output d_valid, d_stall, d_pc, d_op,
    output d_rt, d_a, d_b, d_pred_taken
  );

  modport slave (
    input d_valid, d_stall, d_pc, d_op,
    input d_rt, d_a, d_b, d_pred_taken
  );
endinterface

// File: rtl/branch_predict_unit_cond.sv
// Branch condition evaluator: op/rt/a/b -> is_branch, taken.
// Ports: op, rt, a, b in; is_branch, taken out (combinational).
module branch_cond
  import branch_predict_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        op,
  input  logic [4:0]        rt,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              is_branch,
  output logic              taken
);

  logic neg;
  logic zero;
  logic rt_lt;
  logic rt_ge;

  assign neg   = a[DATA_W-1];
  assign zero  = (a == '0);
  assign rt_lt = (rt == EXE_BLTZ) | (rt == EXE_BLTZAL);
  assign rt_ge = (rt == EXE_BGEZ) | (rt == EXE_BGEZAL);

  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    unique case (1'b1)
      op == EXE_BEQ: begin
        is_branch = 1'b1;
        taken     = (a == b);
      end
      op == EXE_BNE: begin
        is_branch = 1'b1;
        taken     = (a != b);
      end
      op == EXE_BLEZ: begin
        is_branch = 1'b1;
        taken     = neg | zero;
      end
      op == EXE_BGTZ: begin
        is_branch = 1'b1;
        taken     = !neg & !zero;
      end
      (op == EXE_REGIMM) && rt_lt: begin
        is_branch = 1'b1;
        taken     = neg;
      end
      (op == EXE_REGIMM) && rt_ge: begin
        is_branch = 1'b1;
        taken     = !neg;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Decode-stage branch resolver with 2-bit counter prediction table.
// Ports: clk/resetn, f_pc->f_pred_taken, d bundle, resolve outs, stats.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter int         IDX_W    = 6,
  parameter int         STAT_W   = 16,
  parameter logic [1:0] INIT_CTR = WNT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          f_pc,
  output logic                 f_pred_taken,
  branch_predict_unit_if.slave d,
  output logic                 d_is_branch,
  output logic                 d_taken,
  output logic                 mispredict,
  input  logic                 stat_clr,
  output logic [STAT_W-1:0]    stat_branches,
  output logic [STAT_W-1:0]    stat_mispredicts
);

  localparam int N = 2 ** IDX_W;

  logic [1:0]       tbl [N];
  logic [IDX_W-1:0] fidx;
  logic [IDX_W-1:0] didx;
  logic [1:0]       nxt;
  logic             resolve;
  logic             miss;

  branch_cond #(.DATA_W(DATA_W)) u_cond (
    .op        (d.d_op),
    .rt        (d.d_rt),
    .a         (d.d_a),
    .b         (d.d_b),
    .is_branch (d_is_branch),
    .taken     (d_taken)
  );

  assign fidx    = f_pc[IDX_W+1:2];
  assign didx    = d.d_pc[IDX_W+1:2];
  assign resolve = d.d_valid & !d.d_stall & d_is_branch;
  assign miss    = resolve & (d_taken != d.d_pred_taken);
  assign nxt     = ctr_next(tbl[didx], d_taken);

  // Same-cycle write to the looked-up entry is forwarded to fetch.
  assign f_pred_taken = (resolve && fidx == didx)
                      ? nxt[1] : tbl[fidx][1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++)
        tbl[i] <= INIT_CTR;
    end else if (resolve) begin
      tbl[didx] <= nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mispredict       <= 1'b0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      mispredict <= miss;
      if (stat_clr) begin
        stat_branches    <= '0;
        stat_mispredicts <= '0;
      end else if (resolve) begin
        if (stat_branches != '1)
          stat_branches <= stat_branches + 1'b1;
        if (miss && stat_mispredicts != '1)
          stat_mispredicts <= stat_mispredicts + 1'b1;
      end
    end
  end

  logic unused_pc;
  assign unused_pc = ^{f_pc[31:IDX_W+2], f_pc[1:0],
                       d.d_pc[31:IDX_W+2], d.d_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: vector table,
// mispredict scoreboard queue and hand-written corner sequences.
module tb_branch_predict_unit;

  logic        clk;
  logic        resetn;
  logic [31:0] f_pc;
  logic        stat_clr;
  logic        f_pred, f_pred2;
  logic        is_br, is_br2;
  logic        tk, tk2;
  logic        mis, mis2;
  logic [15:0] sb, sm;
  logic [1:0]  sb2, sm2;

  branch_predict_unit_if #(.DATA_W(32)) bif ();

  branch_predict_unit dut (
    .clk (clk), .resetn (resetn),
    .f_pc (f_pc), .f_pred_taken (f_pred),
    .d (bif.slave),
    .d_is_branch (is_br), .d_taken (tk),
    .mispredict (mis), .stat_clr (stat_clr),
    .stat_branches (sb), .stat_mispredicts (sm)
  );

  branch_predict_unit #(.STAT_W(2)) dut2 (
    .clk (clk), .resetn (resetn),
    .f_pc (f_pc), .f_pred_taken (f_pred2),
    .d (bif.slave),
    .d_is_branch (is_br2), .d_taken (tk2),
    .mispredict (mis2), .stat_clr (stat_clr),
    .stat_branches (sb2), .stat_mispredicts (sm2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] a;
    logic [31:0] b;
    logic        br;
    logic        tk;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic [1:0]  mctr [64];
  logic [15:0] mb, mm;
  logic [1:0]  mb2, mm2;
  logic        q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] mstep(input logic [1:0] c,
                                      input logic t);
    case ({t, c})
      3'b100: return 2'b01;
      3'b101: return 2'b10;
      3'b110: return 2'b11;
      3'b111: return 2'b11;
      3'b000: return 2'b00;
      3'b001: return 2'b00;
      3'b010: return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  task automatic mreset();
    for (int i = 0; i < 64; i++) mctr[i] = 2'b01;
    mb = 0; mm = 0; mb2 = 0; mm2 = 0;
  endtask

  task automatic idle();
    bif.d_valid = 0; bif.d_stall = 0; bif.d_pc = 0;
    bif.d_op = 0; bif.d_rt = 0; bif.d_a = 0; bif.d_b = 0;
    bif.d_pred_taken = 0; stat_clr = 0;
  endtask

  // Called at negedge; returns at the following negedge.
  task automatic step(
    input logic v, input logic st, input logic [31:0] pc,
    input logic [5:0] op, input logic [4:0] rt,
    input logic [31:0] a, input logic [31:0] b,
    input logic pr, input logic ebr, input logic etk,
    input logic [31:0] fpc, input logic clr
  );
    logic       res, em, ep;
    logic [5:0] fi, di;
    logic [1:0] nv;
    bif.d_valid = v; bif.d_stall = st; bif.d_pc = pc;
    bif.d_op = op; bif.d_rt = rt; bif.d_a = a; bif.d_b = b;
    bif.d_pred_taken = pr; f_pc = fpc; stat_clr = clr;
    #1;
    res = v & !st & ebr;
    fi  = fpc[7:2];
    di  = pc[7:2];
    nv  = mstep(mctr[di], etk);
    ep  = (res && fi == di) ? nv[1] : mctr[fi][1];
    chk("is_branch", is_br, ebr);
    chk("taken", tk, etk);
    chk("f_pred", f_pred, ep);
    chk("f_pred2", f_pred2, ep);
    q.push_back(res & (etk != pr));
    @(posedge clk);
    if (res) mctr[di] = nv;
    if (clr) begin
      mb = 0; mm = 0; mb2 = 0; mm2 = 0;
    end else if (res) begin
      if (mb != 16'hffff) mb++;
      if (mb2 != 2'b11) mb2++;
      if (etk != pr) begin
        if (mm != 16'hffff) mm++;
        if (mm2 != 2'b11) mm2++;
      end
    end
    #1;
    em = q.pop_front();
    chk("mispredict", mis, em);
    chk("mispredict2", mis2, em);
    chk("stat_br", sb, mb);
    chk("stat_mp", sm, mm);
    chk("stat_br2", sb2, mb2);
    chk("stat_mp2", sm2, mm2);
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    idle();
    resetn = 0;
    mreset();
    #1;
    chk("rst_f_pred", f_pred, 0);
    chk("rst_mis", mis, 0);
    chk("rst_sb", sb, 0);
    chk("rst_sm", sm, 0);
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
  endtask

  vec_t vt [19];

  initial begin
    vt[0]  = '{6'd4, 5'd0, 32'd5, 32'd5, 1, 1};
    vt[1]  = '{6'd4, 5'd0, 32'd5, 32'd6, 1, 0};
    vt[2]  = '{6'd5, 5'd0, 32'd5, 32'd6, 1, 1};
    vt[3]  = '{6'd5, 5'd0, 32'd7, 32'd7, 1, 0};
    vt[4]  = '{6'd6, 5'd0, 32'd0, 32'd9, 1, 1};
    vt[5]  = '{6'd6, 5'd0, 32'h80000000, 32'd0, 1, 1};
    vt[6]  = '{6'd6, 5'd0, 32'd1, 32'd0, 1, 0};
    vt[7]  = '{6'd7, 5'd0, 32'd1, 32'd0, 1, 1};
    vt[8]  = '{6'd7, 5'd0, 32'd0, 32'd0, 1, 0};
    vt[9]  = '{6'd7, 5'd0, 32'hffffffff, 32'd0, 1, 0};
    vt[10] = '{6'd1, 5'd0, 32'hffffffff, 32'd0, 1, 1};
    vt[11] = '{6'd1, 5'd0, 32'd0, 32'd0, 1, 0};
    vt[12] = '{6'd1, 5'd16, 32'h80000000, 32'd0, 1, 1};
    vt[13] = '{6'd1, 5'd1, 32'd0, 32'd0, 1, 1};
    vt[14] = '{6'd1, 5'd1, 32'hfffffffb, 32'd0, 1, 0};
    vt[15] = '{6'd1, 5'd17, 32'd0, 32'd0, 1, 1};
    vt[16] = '{6'd1, 5'd2, 32'hffffffff, 32'd0, 0, 0};
    vt[17] = '{6'd0, 5'd0, 32'd3, 32'd3, 0, 0};
    vt[18] = '{6'd2, 5'd0, 32'd3, 32'd3, 0, 0};

    idle();
    f_pc = 32'h100;
    resetn = 0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 19; i++) begin
      logic [31:0] pc;
      pc = 32'h1004 + 32'(4 * i);
      step(1, 0, pc, vt[i].op, vt[i].rt, vt[i].a, vt[i].b,
           1'(i % 2), vt[i].br, vt[i].tk, pc, 0);
    end

    do_reset();
    // BEQ taken twice at 0x100, predicted not-taken.
    step(1, 0, 32'h100, 6'd4, 0, 5, 5, 0, 1, 1, 32'h104, 0);
    step(1, 0, 32'h100, 6'd4, 0, 5, 5, 0, 1, 1, 32'h104, 0);
    f_pc = 32'h100;
    #1 chk("beq_pred_100", f_pred, 1);
    // BGTZ on negative operand, predicted taken.
    step(1, 0, 32'h104, 6'd7, 0, 32'h80000000, 0, 1, 1, 0,
         32'h104, 0);
    f_pc = 32'h104;
    #1 chk("bgtz_pred_104", f_pred, 0);
    // BGEZAL held in stall for three cycles.
    for (int i = 0; i < 3; i++)
      step(1, 1, 32'h108, 6'd1, 17, 0, 0, 1, 1, 1, 32'h108, 0);
    step(1, 0, 32'h108, 6'd1, 17, 0, 0, 1, 1, 1, 32'h108, 0);
    chk("stall_br", sb, 4);
    chk("stall_mp", sm, 3);

    // Saturation of the narrow counters.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10c, 1);
    for (int i = 0; i < 5; i++)
      step(1, 0, 32'h10c, 6'd4, 0, 1, 1, 0, 1, 1, 32'h10c, 0);
    chk("sat_br2", sb2, 3);
    chk("sat_mp2", sm2, 3);
    chk("wide_br", sb, 5);
    step(1, 0, 32'h10c, 6'd4, 0, 1, 1, 0, 1, 1, 32'h10c, 1);
    chk("clr_br2", sb2, 0);
    chk("clr_mp", sm, 0);

    // Asynchronous reset during a mispredicting resolve at 0x100.
    bif.d_valid = 1; bif.d_pc = 32'h100; bif.d_op = 6'd4;
    bif.d_a = 5; bif.d_b = 5; bif.d_pred_taken = 0;
    f_pc = 32'h104;
    #2 resetn = 0;
    #1 idle();
    f_pc = 32'h100;
    @(posedge clk);
    #1;
    mreset();
    chk("midrst_pred", f_pred, 0);
    chk("midrst_mis", mis, 0);
    chk("midrst_sb", sb, 0);
    @(negedge clk);
    resetn = 1;
    @(negedge clk);

    // Bypass: resolve and lookup of 0x200 in the same cycle.
    step(1, 0, 32'h200, 6'd4, 0, 9, 9, 1, 1, 1, 32'h200, 0);
    f_pc = 32'h200;
    #1 chk("bypass_after", f_pred, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1, "timeout");
  end

endmodule
